// File: rtl/serial_add_ctrl_if.sv
// Host-side handshake and result bus of the bit-serial adder sequencer.
// The sub field only exists when SERIAL_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

`ifdef SERIAL_SUB_EN
  modport master (output start, op_a, op_b, sub, input busy, done, result, carry_out);
  modport slave  (input start, op_a, op_b, sub, output busy, done, result, carry_out);
`else
  modport master (output start, op_a, op_b, input busy, done, result, carry_out);
  modport slave  (input start, op_a, op_b, output busy, done, result, carry_out);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial sequencer driving one shared external full-adder cell, LSB first.
// Optional subtract mode (b inverted, carry-in 1) is enabled by SERIAL_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus,
  output logic               fa_a,
  output logic               fa_b,
  output logic               fa_cin,
  input  logic               fa_sum,
  input  logic               fa_carry
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_q;
  logic             carry, cout_q, done_q;
  logic [CNT_W-1:0] cnt;
  logic             load, run, last;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

`ifdef SERIAL_SUB_EN
  assign b_load   = bus.sub ? ~bus.op_b : bus.op_b;
  assign cin_load = bus.sub;
`else
  assign b_load   = bus.op_b;
  assign cin_load = 1'b0;
`endif

  assign run  = (state_q == RUN);
  assign last = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN:  if (cnt == LAST) state_d = DONE;
      DONE: begin
        // a start in the DONE cycle chains straight into the next RUN
        load    = bus.start;
        state_d = bus.start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (load) begin
        a_sr  <= bus.op_a;
        b_sr  <= b_load;
        carry <= cin_load;
        cnt   <= '0;
      end else if (run) begin
        res_q <= {fa_sum, res_q[WIDTH-1:1]};
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        carry <= fa_carry;
        cnt   <= cnt + 1'b1;
        if (last) cout_q <= fa_carry;
      end
    end
  end

  assign fa_a   = run & a_sr[0];
  assign fa_b   = run & b_sr[0];
  assign fa_cin = run & carry;

  assign bus.busy      = run;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl with a behavioural full-adder cell and
// an arithmetic reference model; define SERIAL_SUB_EN to cover subtract mode.
module tb_serial_add_ctrl;
  localparam int W = 8;
  localparam longint MASK = (64'd1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic fa_a, fa_b, fa_cin, fa_sum, fa_carry;
  logic sub_v;
  int   checks = 0;
  int   errors = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_carry(fa_carry)
  );

`ifdef SERIAL_SUB_EN
  assign bus.sub = sub_v;
`endif

  // the shared adder cell
  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_carry = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue start and advance into RUN cycle 0
  task automatic issue(input longint a, input longint b, input logic s);
    bus.start = 1'b1; bus.op_a = W'(a); bus.op_b = W'(b); sub_v = s;
    tick();
    bus.start = 1'b0;
  endtask

  // Walk the WIDTH RUN cycles checking the adder-cell drive, then check the
  // DONE cycle. Optionally raise start (new operands) at RUN cycle inj; with
  // keep set, start stays high into the DONE cycle.
  task automatic check_run(input longint a, input longint b, input logic s,
                           input int inj, input longint na, input longint nb,
                           input logic keep);
    longint bb, c0, cin_i, exp_res, exp_co;
    bb = s ? (~b & MASK) : b;
    c0 = s ? 1 : 0;
    for (int i = 0; i < W; i++) begin
      cin_i = ((a & ((64'd1 << i) - 1)) + (bb & ((64'd1 << i) - 1)) + c0) >> i;
      chk("busy_run", bus.busy, 1);
      chk("done_run", bus.done, 0);
      chk("fa_a", fa_a, (a >> i) & 1);
      chk("fa_b", fa_b, (bb >> i) & 1);
      chk("fa_cin", fa_cin, cin_i & 1);
      if (i == inj) begin
        bus.start = 1'b1; bus.op_a = W'(na); bus.op_b = W'(nb);
      end else if (!keep) begin
        bus.start = 1'b0;
      end
      tick();
    end
    exp_res = s ? ((a - b) & MASK) : ((a + b) & MASK);
    exp_co  = s ? ((a >= b) ? 1 : 0) : (((a + b) >> W) & 1);
    chk("done", bus.done, 1);
    chk("busy_done", bus.busy, 0);
    chk("result", bus.result, exp_res);
    chk("carry_out", bus.carry_out, exp_co);
    chk("fa_cin_idle", fa_cin, 0);
  endtask

  task automatic add_op(input longint a, input longint b, input logic s);
    issue(a, b, s);
    check_run(a, b, s, -1, 0, 0, 1'b0);
    tick();
    chk("done_once", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    longint a, b;
    logic   s;
    rst = 1'b1; bus.start = 1'b1; bus.op_a = 8'h12; bus.op_b = 8'h34; sub_v = 1'b0;
    tick(); tick();
    bus.start = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_carry", bus.carry_out, 0);
    chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);

    add_op(64'h35, 64'h4A, 1'b0);
    add_op(64'hFF, 64'h01, 1'b0);

    // start during RUN is ignored
    issue(64'h0F, 64'h01, 1'b0);
    check_run(64'h0F, 64'h01, 1'b0, 2, 64'hAA, 64'h55, 1'b0);
    tick();
    chk("ign_done_once", bus.done, 0);
    chk("ign_busy", bus.busy, 0);
    chk("ign_result_hold", bus.result, 64'h10);

    // start held through DONE chains into the next add
    issue(64'h11, 64'h22, 1'b0);
    check_run(64'h11, 64'h22, 1'b0, W - 1, 64'h80, 64'h80, 1'b1);
    tick();
    bus.start = 1'b0;
    chk("b2b_done_once", bus.done, 0);
    chk("b2b_busy", bus.busy, 1);
    check_run(64'h80, 64'h80, 1'b0, -1, 0, 0, 1'b0);
    tick();
    chk("b2b_idle", bus.busy, 0);

    for (int n = 0; n < 40; n++) begin
      a = longint'($urandom_range(0, 255));
      b = longint'($urandom_range(0, 255));
`ifdef SERIAL_SUB_EN
      s = logic'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      add_op(a, b, s);
    end

    // reset mid-RUN aborts with no done
    add_op(64'hFF, 64'hFF, 1'b0);
    issue(64'h33, 64'h44, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_carry", bus.carry_out, 0);
    for (int i = 0; i < W + 3; i++) begin
      chk("abort_no_done", bus.done, 0);
      tick();
    end
    add_op(64'h01, 64'h02, 1'b0);

`ifdef SERIAL_SUB_EN
    add_op(64'h10, 64'h01, 1'b1);
    add_op(64'h01, 64'h02, 1'b1);
    add_op(64'h5A, 64'h5A, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
